// File: rtl/nanojeff_pkg.sv
// Shared register offsets, STATUS bit positions and transmitter states for the nanojeff UART I/O block.
package nanojeff_pkg;

  localparam logic [1:0] OFF_LEDREG = 2'd0;
  localparam logic [1:0] OFF_TXDATA = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_DIV    = 2'd3;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_HOLD_FULL = 1;
  localparam int STAT_OVERRUN   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/nanojeff_uart_tx.sv
// 8N1 serial shifter: takes the offered byte one edge after load rises, bit time = div+1 cycles.
// No backpressure beyond load/load_ack; the divisor is sampled only at bit boundaries.
module nanojeff_uart_tx
  import nanojeff_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] div,
  input  logic       load,
  input  logic [7:0] load_byte,
  output logic       load_ack,
  output logic       busy,
  output logic       tx
);

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic       tx_q, tx_d;
  logic       bit_tick;

  assign bit_tick = (baud_q == 8'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shift_q <= 8'd0;
      baud_q  <= 8'd0;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (load) state_d = ST_START;
      ST_START: if (bit_tick) state_d = ST_DATA;
      ST_DATA:  if (bit_tick && bit_q == 3'd7) state_d = ST_STOP;
      ST_STOP:  if (bit_tick) state_d = load ? ST_START : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_ack = load && ((state_q == ST_IDLE) || (state_q == ST_STOP && bit_tick));
    busy     = (state_q != ST_IDLE);

    shift_d = shift_q;
    if (load_ack)
      shift_d = load_byte;
    else if (state_q == ST_DATA && bit_tick)
      shift_d = {1'b0, shift_q[7:1]};

    bit_d = bit_q;
    if (state_d == ST_START)
      bit_d = 3'd0;
    else if (state_q == ST_DATA && bit_tick)
      bit_d = bit_q + 3'd1;

    // Reload only at a bit boundary, so a divisor change never stretches the bit in flight.
    baud_d = baud_q - 8'd1;
    if (state_q == ST_IDLE || bit_tick)
      baud_d = div;

    unique case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx = tx_q;

endmodule

// File: rtl/nanojeff_uart_io.sv
// Memory-mapped LED + UART transmit window: decode, registers and combinational read mux.
// Writes complete in one edge; a TXDATA write while the holding byte is full is dropped and flagged.
module nanojeff_uart_io
  import nanojeff_pkg::*;
#(
  parameter logic [7:0] IO_BASE   = 8'hF0,
  parameter logic [7:0] DIV_RESET = 8'd15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] daddr,
  input  logic [7:0] wdata,
  input  logic       wen,
  output logic [7:0] rdata,
  output logic       io_sel,
  output logic       led,
  output logic       uart_tx
);

  logic [7:0] off;
  logic [1:0] reg_sel;
  logic       wr_en;

  logic       led_q, led_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       overrun_q, overrun_d;
  logic [7:0] div_q, div_d;

  logic       load_ack;
  logic       tx_busy;
  logic [7:0] status_val;

  // Offset arithmetic keeps the window check correct even if the window sits at the top of the map.
  assign off     = daddr - IO_BASE;
  assign io_sel  = (off[7:2] == 6'd0);
  assign reg_sel = off[1:0];
  assign wr_en   = wen && io_sel;

  always_ff @(posedge clk) begin
    if (!reset) begin
      led_q       <= 1'b0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      overrun_q   <= 1'b0;
      div_q       <= DIV_RESET;
    end else begin
      led_q       <= led_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      overrun_q   <= overrun_d;
      div_q       <= div_d;
    end
  end

  always_comb begin
    led_d       = led_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    overrun_d   = overrun_q;
    div_d       = div_q;

    if (load_ack)
      hold_full_d = 1'b0;

    if (wr_en) begin
      unique case (reg_sel)
        OFF_LEDREG: led_d = wdata[0];
        OFF_TXDATA: begin
          // A write landing on the drain edge sees the slot as free.
          if (hold_full_q && !load_ack) begin
            overrun_d = 1'b1;
          end else begin
            hold_d      = wdata;
            hold_full_d = 1'b1;
          end
        end
        OFF_STATUS: if (wdata[STAT_OVERRUN]) overrun_d = 1'b0;
        OFF_DIV:    div_d = wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    status_val                 = 8'd0;
    status_val[STAT_BUSY]      = tx_busy;
    status_val[STAT_HOLD_FULL] = hold_full_q;
    status_val[STAT_OVERRUN]   = overrun_q;

    rdata = 8'h00;
    if (io_sel) begin
      unique case (reg_sel)
        OFF_LEDREG: rdata = {7'd0, led_q};
        OFF_TXDATA: rdata = 8'h00;
        OFF_STATUS: rdata = status_val;
        OFF_DIV:    rdata = div_q;
        default:    rdata = 8'h00;
      endcase
    end
  end

  nanojeff_uart_tx u_tx (
    .clk       (clk),
    .reset     (reset),
    .div       (div_q),
    .load      (hold_full_q),
    .load_byte (hold_q),
    .load_ack  (load_ack),
    .busy      (tx_busy),
    .tx        (uart_tx)
  );

  assign led = led_q;

endmodule

// File: tb/tb_nanojeff_uart_io.sv
// Scoreboard bench: stimulus queues expected register/pin values and per-cycle uart_tx levels; a negedge monitor compares.
module tb_nanojeff_uart_io;

  localparam int K_RDATA = 0;
  localparam int K_LED   = 1;
  localparam int K_IOSEL = 2;
  localparam int K_TX    = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] daddr;
  logic [7:0] wdata;
  logic       wen;
  logic [7:0] rdata;
  logic       io_sel;
  logic       led;
  logic       uart_tx;

  typedef struct {
    string      name;
    int         kind;
    logic [7:0] exp;
  } chk_t;

  chk_t chk_q[$];
  logic wave_q[$];
  logic chk_vld = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   wave_idx = 0;

  nanojeff_uart_io #(.IO_BASE(8'hF0), .DIV_RESET(8'd15)) dut (
    .clk     (clk),
    .reset   (reset),
    .daddr   (daddr),
    .wdata   (wdata),
    .wen     (wen),
    .rdata   (rdata),
    .io_sel  (io_sel),
    .led     (led),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  chk_t       cur;
  logic [7:0] act;
  logic       exp_bit;

  always @(negedge clk) begin
    if (chk_vld) begin
      checks++;
      if (chk_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty got strobe want queued entry");
      end else begin
        cur = chk_q.pop_front();
        case (cur.kind)
          K_RDATA: act = rdata;
          K_LED:   act = {7'd0, led};
          K_IOSEL: act = {7'd0, io_sel};
          default: act = {7'd0, uart_tx};
        endcase
        if (act !== cur.exp) begin
          errors++;
          $display("FAIL %s got %02h want %02h", cur.name, act, cur.exp);
        end
      end
    end
    if (wave_q.size() > 0) begin
      exp_bit = wave_q.pop_front();
      checks++;
      if (uart_tx !== exp_bit) begin
        errors++;
        $display("FAIL uart_tx_cycle%0d got %0b want %0b", wave_idx, uart_tx, exp_bit);
      end
      wave_idx++;
    end
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    daddr = a;
    wdata = d;
    wen   = 1'b1;
    @(posedge clk);
    #1 wen = 1'b0;
  endtask

  task automatic chk(input string name, input int kind, input logic [7:0] a, input logic [7:0] e);
    chk_t c;
    c.name = name;
    c.kind = kind;
    c.exp  = e;
    daddr  = a;
    chk_q.push_back(c);
    chk_vld = 1'b1;
    @(posedge clk);
    #1 chk_vld = 1'b0;
  endtask

  task automatic push_lvl(input logic lvl, input int n);
    for (int i = 0; i < n; i++) wave_q.push_back(lvl);
  endtask

  task automatic push_frame(input logic [7:0] b, input int bt);
    push_lvl(1'b0, bt);
    for (int i = 0; i < 8; i++) push_lvl(b[i], bt);
    push_lvl(1'b1, bt);
  endtask

  task automatic wait_wave(input string name);
    for (int i = 0; i < 2000 && wave_q.size() > 0; i++) @(posedge clk);
    #1;
    if (wave_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got %0d pending want 0", name, wave_q.size());
      wave_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    daddr = 8'h00;
    wdata = 8'h00;
    wen   = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    chk("rst_status", K_RDATA, 8'hF2, 8'h00);
    chk("rst_div",    K_RDATA, 8'hF3, 8'h0F);
    chk("rst_led",    K_LED,   8'hF0, 8'h00);
    chk("rst_tx",     K_TX,    8'hF0, 8'h01);
    chk("iosel_f3",   K_IOSEL, 8'hF3, 8'h01);
    chk("iosel_f4",   K_IOSEL, 8'hF4, 8'h00);
    chk("iosel_ef",   K_IOSEL, 8'hEF, 8'h00);
    chk("rdata_out",  K_RDATA, 8'hEF, 8'h00);

    wr(8'hF0, 8'hFF);
    chk("led_on",     K_LED,   8'hF0, 8'h01);
    chk("rd_ledreg",  K_RDATA, 8'hF0, 8'h01);
    chk("rd_txdata",  K_RDATA, 8'hF1, 8'h00);
    wr(8'hEF, 8'h00);
    chk("led_outwr",  K_LED,   8'hF0, 8'h01);

    wr(8'hF3, 8'h00);
    wr(8'hF1, 8'hA5);
    push_lvl(1'b1, 1);
    push_frame(8'hA5, 1);
    push_lvl(1'b1, 4);
    chk("a5_holdfull", K_RDATA, 8'hF2, 8'h02);
    wait_wave("a5");
    chk("a5_idle",     K_RDATA, 8'hF2, 8'h00);

    wr(8'hF3, 8'h03);
    wr(8'hF1, 8'h55);
    push_lvl(1'b1, 1);
    push_frame(8'h55, 4);
    push_frame(8'hAA, 4);
    push_lvl(1'b1, 12);
    wr(8'hF1, 8'hAA);
    wr(8'hF1, 8'h11);
    chk("ovr_status",  K_RDATA, 8'hF2, 8'h07);
    chk("ovr_div",     K_RDATA, 8'hF3, 8'h03);
    wait_wave("b2b");
    chk("ovr_sticky",  K_RDATA, 8'hF2, 8'h04);
    wr(8'hF2, 8'h04);
    chk("ovr_cleared", K_RDATA, 8'hF2, 8'h00);

    wr(8'hF3, 8'h01);
    wr(8'hF1, 8'h0F);
    push_lvl(1'b1, 1);
    push_lvl(1'b0, 2);
    for (int i = 0; i < 8; i++) push_lvl((i < 4) ? 1'b1 : 1'b0, 5);
    push_lvl(1'b1, 5);
    push_lvl(1'b1, 4);
    @(posedge clk);
    #1 wr(8'hF3, 8'h04);
    wait_wave("divchg");
    chk("divchg_div",  K_RDATA, 8'hF3, 8'h04);

    wr(8'hF3, 8'h00);
    wr(8'hF1, 8'h00);
    push_lvl(1'b1, 1);
    push_lvl(1'b0, 5);
    push_lvl(1'b1, 12);
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    chk("rstmid_status", K_RDATA, 8'hF2, 8'h00);
    chk("rstmid_div",    K_RDATA, 8'hF3, 8'h0F);
    chk("rstmid_led",    K_LED,   8'hF0, 8'h00);
    wait_wave("rstmid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nanojeff_uart_io.md
NANOJEFF_UART_IO -- requirements
Module: nanojeff_uart_io

Interface
REQ-001 The block SHALL have parameter IO_BASE, default 8'hF0, meaning the base data address of the 4-byte register window.
REQ-002 The block SHALL have parameter DIV_RESET, default 8'd15, meaning the reset value of the baud divisor register.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, reset that is synchronous and active-low.
REQ-005 The block SHALL have port daddr, input, 8, the CPU data address.
REQ-006 The block SHALL have port wdata, input, 8, the CPU write data.
REQ-007 The block SHALL have port wen, input, 1, the CPU write enable, sampled at clk rise.
REQ-008 The block SHALL have port rdata, output, 8, the combinational read data for the addressed register, 8'h00 outside the window.
REQ-009 The block SHALL have port io_sel, output, 1, high when daddr is in IO_BASE..IO_BASE+3; the top level uses it to steer reads away from memory and to suppress memory writes.
REQ-010 The block SHALL have port led, output, 1, LED drive, equal to LEDREG bit 0.
REQ-011 The block SHALL have port uart_tx, output, 1, the registered serial line, idle high.

Function
REQ-012 The register map SHALL be: +0 LEDREG (bit0 r/w, bits7:1 read 0); +1 TXDATA (write-only, reads 0); +2 STATUS (bit0 busy, bit1 hold_full, bit2 overrun, others 0); +3 DIV (r/w).
REQ-013 A write SHALL take effect when wen=1 and io_sel=1 at clk rise; writes outside the window SHALL be ignored.
REQ-014 A write to TXDATA with hold_full=0 SHALL load the holding byte and set hold_full.
REQ-015 A write to TXDATA with hold_full=1 SHALL be discarded, SHALL set sticky overrun, and SHALL leave the holding byte unchanged.
REQ-016 A write to STATUS with wdata bit2=1 SHALL clear overrun; other STATUS bits SHALL be read-only.
REQ-017 The transmitter FSM SHALL have states IDLE, START, DATA, STOP.
REQ-018 In IDLE with hold_full=1, the FSM SHALL move to START on the next edge, copy the holding byte to the shifter, and clear hold_full.
REQ-019 uart_tx SHALL then be low for one bit time in START, SHALL output data bits LSB first in DATA (8 bits, bit counter 0..7), and SHALL be high for one bit time in STOP.
REQ-020 From STOP, the FSM SHALL go to START directly if hold_full=1, else to IDLE, with no idle bit between back-to-back frames.
REQ-021 One bit time SHALL equal DIV+1 clk cycles; DIV=0 SHALL give 1 cycle per bit; the 8-bit baud counter SHALL reload at each bit boundary.
REQ-022 A DIV write mid-frame SHALL take effect at the next bit boundary only.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 A TXDATA write on the same edge the FSM drains the holding byte SHALL be accepted into the holding register with no overrun.
REQ-025 Latency SHALL be: TXDATA write at edge N with FSM IDLE gives uart_tx low after edge N+1.

Reset
REQ-026 While reset=0 at a clk rise, the block SHALL set FSM=IDLE, uart_tx=1, led=0, hold_full=0, overrun=0, DIV=DIV_RESET, and clear the shifter and counters.
REQ-027 A reset mid-frame SHALL return uart_tx high after that edge, and the frame SHALL be abandoned.
REQ-028 rdata and io_sel SHALL remain combinational from daddr during reset.

Structure
REQ-029 Package nanojeff_pkg SHALL hold the register offsets (LEDREG, TXDATA, STATUS, DIV), the STATUS bit positions, and the FSM state enum.
REQ-030 The shifter, baud counter and FSM SHALL be one sub-module, nanojeff_uart_tx, with load/byte/busy/tx ports.
REQ-031 Address decode, registers and the read mux SHALL stay in the top level.

Verification
REQ-032 The bench SHALL cover reset defaults: read +2 -> 8'h00, read +3 -> 8'h0F, uart_tx=1, led=0.
REQ-033 The bench SHALL cover LED: write 8'hFF to +0 -> led=1 next cycle, read +0 -> 8'h01; a write to 8'hEF SHALL not change led.
REQ-034 The bench SHALL cover one frame: DIV=0, write 8'hA5 to +1 -> from edge N+1 uart_tx = 0,1,0,1,0,0,1,0,1,1 for one cycle each, then busy=0.
REQ-035 The bench SHALL cover back-to-back and overrun: DIV=3, write 8'h55 then 8'hAA, then 8'h11 while hold_full=1 -> two frames with no gap, 8'h11 never sent, STATUS bit2=1; writing 8'h04 to +2 SHALL clear it.
REQ-036 The bench SHALL cover reset mid-frame: during DATA bit 3, reset=0 for one edge -> uart_tx=1, STATUS=8'h00, with no further transitions.
REQ-037 The bench SHALL cover a mid-frame DIV change from 1 to 4 -> the current bit stays 2 cycles and the following bits are 5 cycles.
